// File: rtl/norm_arbiter_if.sv
// Handshake and result bus of the two-stream norm arbiter.
// slave is the arbiter side; master is the producer/consumer side.
interface norm_arbiter_if;
  logic [7:0] a0;
  logic       valid_in0;
  logic       ready0;
  logic [7:0] a1;
  logic       valid_in1;
  logic       ready1;
  logic [9:0] g;
  logic       src;
  logic       valid_out;
  logic       busy;

  modport slave (
    input  a0, valid_in0, a1, valid_in1,
    output ready0, ready1, g, src, valid_out, busy
  );

  modport master (
    output a0, valid_in0, a1, valid_in1,
    input  ready0, ready1, g, src, valid_out, busy
  );
endinterface

// File: rtl/norm_arbiter.sv
// Round-robin frame scheduler sharing one sum-of-squares accumulator and
// integer square root between two sample streams.
module norm_arbiter #(
  parameter int FRAME_LEN = 4
) (
  input  logic           clk,
  input  logic           reset,
  norm_arbiter_if.slave  bus
);
  localparam int         NUM_REQ  = 2;
  localparam logic [3:0] LAST_CNT = 4'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, ACC, ROOT} state_t;

  state_t      state, state_nxt;
  logic        owner, owner_nxt;
  logic        last, last_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic [19:0] acc, acc_nxt;
  logic [9:0]  g, g_nxt;
  logic        src, src_nxt;
  logic        vo, vo_nxt;
  logic        grant;

  logic [NUM_REQ-1:0][7:0] a;
  logic [NUM_REQ-1:0]      vin;
  logic [NUM_REQ-1:0]      rdy;
  logic [7:0]              a_own;
  logic [15:0]             sq;
  logic [9:0]              root;

  // Digit-by-digit square root: two radicand bits per result bit.
  function automatic logic [9:0] isqrt(input logic [19:0] x);
    logic [21:0] rem;
    logic [21:0] trial;
    logic [19:0] xs;
    logic [9:0]  r;
    rem = '0;
    r   = '0;
    xs  = x;
    for (int i = 0; i < 10; i++) begin
      rem   = {rem[19:0], xs[19:18]};
      xs    = {xs[17:0], 2'b00};
      trial = {10'd0, r, 2'b01};
      if (rem >= trial) begin
        rem = rem - trial;
        r   = {r[8:0], 1'b1};
      end else begin
        r   = {r[8:0], 1'b0};
      end
    end
    return r;
  endfunction

  assign a   = {bus.a1, bus.a0};
  assign vin = {bus.valid_in1, bus.valid_in0};

  // ready comes from registered state only, never from valid_in
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rdy
    assign rdy[i] = (state == ACC) && (owner == 1'(i));
  end

  assign a_own = a[owner];
  assign sq    = 16'(a_own) * 16'(a_own);
  assign root  = isqrt(acc);

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    g_nxt     = g;
    src_nxt   = src;
    vo_nxt    = 1'b0;
    grant     = 1'b0;
    case (state)
      IDLE: begin
        if (vin != '0) begin
          grant     = (&vin) ? ~last : vin[1];
          owner_nxt = grant;
          last_nxt  = grant;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = ACC;
        end
      end
      ACC: begin
        if (vin[owner]) begin
          acc_nxt = acc + {4'd0, sq};
          cnt_nxt = cnt + 4'd1;
          if (cnt == LAST_CNT) state_nxt = ROOT;
        end
      end
      ROOT: begin
        g_nxt     = root;
        src_nxt   = owner;
        vo_nxt    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // last resets to 1 so requester 0 wins the first tie
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
      cnt   <= '0;
      acc   <= '0;
      g     <= '0;
      src   <= 1'b0;
      vo    <= 1'b0;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
      g     <= g_nxt;
      src   <= src_nxt;
      vo    <= vo_nxt;
    end
  end

  assign bus.ready0    = rdy[0];
  assign bus.ready1    = rdy[1];
  assign bus.g         = g;
  assign bus.src       = src;
  assign bus.valid_out = vo;
  assign bus.busy      = (state == ACC) || (state == ROOT);
endmodule

// File: tb/tb_norm_arbiter.sv
// Scoreboard bench for norm_arbiter: three instances cover FRAME_LEN 4, 16 and 1.
module tb_norm_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, rst4;
  int   cyc = 0;
  int   n_chk = 0, n_fail = 0;

  norm_arbiter_if if4 ();
  norm_arbiter_if if16 ();
  norm_arbiter_if if1 ();

  norm_arbiter #(.FRAME_LEN(4))  u4  (.clk(clk), .reset(rst4), .bus(if4));
  norm_arbiter #(.FRAME_LEN(16)) u16 (.clk(clk), .reset(rst),  .bus(if16));
  norm_arbiter #(.FRAME_LEN(1))  u1  (.clk(clk), .reset(rst),  .bus(if1));

  typedef struct packed {logic src; logic [9:0] g;} res_t;
  res_t exp4[$], exp16[$], exp1[$];
  int   st0[$], st1[$];
  bit   hs0 = 0, hs1 = 0;
  int   lacc0 = -10, lacc1 = -10;
  int   phase = 0;
  int   pushed16 = 0, k16 = 0, pushed1 = 0;
  bit   tog1 = 0;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic void push4(input bit s, input int gv);
    exp4.push_back('{src: s, g: 10'(gv)});
  endfunction

  task automatic wait_empty(input string tag, input int budget);
    int n = 0;
    while (exp4.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, exp4.size(), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // FRAME_LEN=4 producers: negative queue entries are one-cycle bubbles
  initial forever begin
    @(negedge clk);
    if (hs0 && st0.size() > 0) begin
      void'(st0.pop_front());
      lacc0 = cyc;
    end
    if (st0.size() > 0 && st0[0] < 0) begin
      void'(st0.pop_front());
      if4.valid_in0 = 1'b0;
      chk("bubble_rdy0", int'(if4.ready0), 1);
    end else if (st0.size() > 0) begin
      if4.a0 = 8'(st0[0]);
      if4.valid_in0 = 1'b1;
    end else begin
      if4.valid_in0 = 1'b0;
    end
    hs0 = if4.valid_in0 && if4.ready0 && rst4;
  end

  initial forever begin
    @(negedge clk);
    if (hs1 && st1.size() > 0) begin
      void'(st1.pop_front());
      lacc1 = cyc;
    end
    if (st1.size() > 0) begin
      if4.a1 = 8'(st1[0]);
      if4.valid_in1 = 1'b1;
    end else begin
      if4.valid_in1 = 1'b0;
    end
    hs1 = if4.valid_in1 && if4.ready1 && rst4;
  end

  // FRAME_LEN=4 result monitor
  initial begin
    int   prev = 0;
    bit   prev_ok = 0;
    res_t e;
    forever begin
      @(negedge clk);
      if (rst4 && if4.valid_out) begin
        if (exp4.size() == 0) chk("u4_unexpected", 1, 0);
        else begin
          e = exp4.pop_front();
          chk("u4_g", int'(if4.g), int'(e.g));
          chk("u4_src", int'(if4.src), int'(e.src));
          chk("u4_latency", cyc, ((lacc0 > lacc1) ? lacc0 : lacc1) + 1);
          if (phase == 2 && prev_ok) chk("u4_period", cyc - prev, 6);
          prev    = cyc;
          prev_ok = (phase == 2);
        end
      end
      if (phase == 1) chk("t1_rdy1", int'(if4.ready1), 0);
    end
  end

  // FRAME_LEN=16: requester 1 streams 255 for two frames
  initial begin
    if16.a0 = 8'd0;
    if16.valid_in0 = 1'b0;
    if16.a1 = 8'd0;
    if16.valid_in1 = 1'b0;
    forever begin
      @(negedge clk);
      if (pushed16 >= 2) if16.valid_in1 = 1'b0;
      else if (rst) begin
        if16.a1 = 8'd255;
        if16.valid_in1 = 1'b1;
      end
      if (if16.valid_in1 && if16.ready1) begin
        k16++;
        if (k16 == 16) begin
          k16 = 0;
          exp16.push_back('{src: 1'b1, g: 10'd1020});
          pushed16++;
        end
      end
    end
  end

  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst && if16.valid_out) begin
        if (exp16.size() == 0) chk("u16_unexpected", 1, 0);
        else begin
          e = exp16.pop_front();
          chk("u16_g", int'(if16.g), int'(e.g));
          chk("u16_src", int'(if16.src), int'(e.src));
        end
      end
    end
  end

  // FRAME_LEN=1: both requesters hold sample 7; sources must alternate from 0
  initial begin
    if1.a0 = 8'd0;
    if1.valid_in0 = 1'b0;
    if1.a1 = 8'd0;
    if1.valid_in1 = 1'b0;
    forever begin
      @(negedge clk);
      if (pushed1 >= 6) begin
        if1.valid_in0 = 1'b0;
        if1.valid_in1 = 1'b0;
      end else if (rst) begin
        if1.a0 = 8'd7;
        if1.a1 = 8'd7;
        if1.valid_in0 = 1'b1;
        if1.valid_in1 = 1'b1;
      end
      if ((if1.valid_in0 && if1.ready0) || (if1.valid_in1 && if1.ready1)) begin
        exp1.push_back('{src: tog1, g: 10'd7});
        tog1 = ~tog1;
        pushed1++;
      end
    end
  end

  initial begin
    int   prev = 0;
    bit   prev_ok = 0;
    res_t e;
    forever begin
      @(negedge clk);
      if (rst && if1.valid_out) begin
        if (exp1.size() == 0) chk("u1_unexpected", 1, 0);
        else begin
          e = exp1.pop_front();
          chk("u1_g", int'(if1.g), int'(e.g));
          chk("u1_src", int'(if1.src), int'(e.src));
          if (prev_ok) chk("u1_period", cyc - prev, 3);
          prev    = cyc;
          prev_ok = 1;
        end
      end
    end
  end

  initial begin
    int n;
    rst  = 1'b1;
    rst4 = 1'b1;
    if4.a0 = 8'd0;
    if4.a1 = 8'd0;
    if4.valid_in0 = 1'b0;
    if4.valid_in1 = 1'b0;
    #1;
    rst  = 1'b0;
    rst4 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_g", int'(if4.g), 0);
    chk("rst_src", int'(if4.src), 0);
    chk("rst_vo", int'(if4.valid_out), 0);
    chk("rst_rdy0", int'(if4.ready0), 0);
    chk("rst_rdy1", int'(if4.ready1), 0);
    chk("rst_busy", int'(if4.busy), 0);
    #2;
    rst  = 1'b1;
    rst4 = 1'b1;

    // both requesting continuously: alternate from requester 0
    @(posedge clk); #1;
    phase = 2;
    for (int i = 0; i < 16; i++) begin
      st0.push_back(1);
      st1.push_back(255);
    end
    for (int i = 0; i < 4; i++) begin
      push4(1'b0, 2);
      push4(1'b1, 510);
    end
    wait_empty("t2_done", 200);
    repeat (3) @(negedge clk);

    // single requester
    @(posedge clk); #1;
    phase = 1;
    st0 = {3, 4, 0, 0};
    push4(1'b0, 5);
    wait_empty("t1_done", 50);
    repeat (2) @(negedge clk);

    // bubbles on requester 0, requester 1 arrives mid-frame
    @(posedge clk); #1;
    phase = 3;
    st0 = {2, -1, 2, -1, -1, 2, -1, 2};
    push4(1'b0, 4);
    n = 0;
    while (st0.size() > 7 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    st1 = {1, 1, 1, 1};
    push4(1'b1, 2);
    repeat (2) @(negedge clk);
    #1;
    chk("t3_rdy1", int'(if4.ready1), 0);
    chk("t3_st1_held", st1.size(), 4);
    chk("t3_busy", int'(if4.busy), 1);
    wait_empty("t3_done", 100);
    repeat (2) @(negedge clk);

    // asynchronous reset mid-frame discards the partial frame
    @(posedge clk); #1;
    phase = 5;
    st0 = {5, 5, 5, 5};
    n = 0;
    while (st0.size() > 2 && n < 30) begin
      @(negedge clk); #1;
      n++;
    end
    chk("t5_two_acc", st0.size(), 2);
    #2;
    rst4 = 1'b0;
    st0.delete();
    #1;
    chk("t5_g", int'(if4.g), 0);
    chk("t5_src", int'(if4.src), 0);
    chk("t5_vo", int'(if4.valid_out), 0);
    chk("t5_rdy0", int'(if4.ready0), 0);
    chk("t5_rdy1", int'(if4.ready1), 0);
    chk("t5_busy", int'(if4.busy), 0);
    repeat (2) @(negedge clk);
    #2;
    rst4 = 1'b1;
    st0 = {3, 4, 0, 0};
    push4(1'b0, 5);
    wait_empty("t5_done", 50);

    n = 0;
    while ((pushed16 < 2 || exp16.size() > 0 || pushed1 < 6 || exp1.size() > 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("u16_frames", pushed16, 2);
    chk("u16_drained", exp16.size(), 0);
    chk("u1_frames", pushed1, 6);
    chk("u1_drained", exp1.size(), 0);
    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
